pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 110 +++++++++++
 tb/tb_pipe_stage_skid.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with ready/valid handshake, a 2-entry skid
// buffer, stall/flush controls and saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int unsigned WIDTH   = 200,
  parameter int unsigned CLK_NEG = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
  } state_t;

  state_t st_q;
  state_t st_d;

  logic accept;
  logic emit;
  logic stall_inc;
  logic bubble_inc;

  // Handshake terms; in_ready depends only on registered state and reset.
  assign in_ready   = !st_q.skid_valid && !Rst;
  assign accept     = in_valid && in_ready && !stall;
  assign emit       = st_q.main_valid && out_ready && !stall;
  assign stall_inc  = stall || (st_q.main_valid && !out_ready);
  assign bubble_inc = !st_q.main_valid && out_ready && !stall;

  assign out_valid  = st_q.main_valid;
  assign out_data   = st_q.main_data;
  assign occupancy  = 2'(st_q.main_valid) + 2'(st_q.skid_valid);
  assign stall_cnt  = st_q.stall_cnt;
  assign bubble_cnt = st_q.bubble_cnt;

  // Next-state: flush > stall > normal main/skid movement.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d.main_valid = 1'b0;
      st_d.skid_valid = 1'b0;
      st_d.main_data  = '0;
      st_d.skid_data  = '0;
    end else if (!stall) begin
      if (!st_q.main_valid || emit) begin
        if (st_q.skid_valid) begin
          st_d.main_valid = 1'b1;
          st_d.main_data  = st_q.skid_data;
          st_d.skid_valid = 1'b0;
          if (accept) begin
            st_d.skid_valid = 1'b1;
            st_d.skid_data  = in_data;
          end
        end else if (accept) begin
          st_d.main_valid = 1'b1;
          st_d.main_data  = in_data;
        end else begin
          st_d.main_valid = 1'b0;
        end
      end else if (accept) begin
        st_d.skid_valid = 1'b1;
        st_d.skid_data  = in_data;
      end
    end

    // Counters freeze during flush and saturate at all-ones.
    if (!flush) begin
      if (stall_inc && (st_q.stall_cnt != CNT_MAX)) begin
        st_d.stall_cnt = st_q.stall_cnt + CNT_W'(1);
      end
      if (bubble_inc && (st_q.bubble_cnt != CNT_MAX)) begin
        st_d.bubble_cnt = st_q.bubble_cnt + CNT_W'(1);
      end
    end
  end

  generate
    if (CLK_NEG != 0) begin : g_neg_edge
      always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) st_q <= '0;
        else     st_q <= st_d;
      end
    end else begin : g_pos_edge
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) st_q <= '0;
        else     st_q <= st_d;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: falling-edge default instance driven
// from a vector table, plus a rising-edge CNT_W=3 instance for saturation.
module tb_pipe_stage_skid;

  localparam int unsigned AW = 200;
  localparam int unsigned BW = 8;
  localparam int unsigned NV = 21;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  // Instance A: defaults (falling edge, 16-bit counters)
  logic          a_in_valid = 1'b0;
  logic [AW-1:0] a_in_data  = '0;
  logic          a_in_ready;
  logic          a_out_valid;
  logic [AW-1:0] a_out_data;
  logic          a_out_ready = 1'b0;
  logic          a_stall = 1'b0;
  logic          a_flush = 1'b0;
  logic [1:0]    a_occ;
  logic [15:0]   a_sc;
  logic [15:0]   a_bc;

  pipe_stage_skid dut_a (
    .Clk(Clk), .Rst(Rst),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .stall(a_stall), .flush(a_flush), .occupancy(a_occ),
    .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  // Instance B: rising edge, 3-bit counters
  logic          b_in_valid = 1'b0;
  logic [BW-1:0] b_in_data  = '0;
  logic          b_in_ready;
  logic          b_out_valid;
  logic [BW-1:0] b_out_data;
  logic          b_out_ready = 1'b0;
  logic          b_stall = 1'b0;
  logic          b_flush = 1'b0;
  logic [1:0]    b_occ;
  logic [2:0]    b_sc;
  logic [2:0]    b_bc;

  pipe_stage_skid #(.WIDTH(BW), .CLK_NEG(0), .CNT_W(3)) dut_b (
    .Clk(Clk), .Rst(Rst),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .stall(b_stall), .flush(b_flush), .occupancy(b_occ),
    .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        st;
    logic        fl;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] sc;
    logic [15:0] bc;
  } vec_t;

  vec_t tbl [NV];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance A updates on negedge; inputs change and outputs are sampled just after posedge.
  task automatic a_cycle();
    @(negedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_a_row(input int i, input vec_t v);
    n_run++;
    if (a_out_valid !== v.ov || a_out_data !== AW'(v.od) || a_occ !== v.occ ||
        a_in_ready !== v.ir || a_sc !== v.sc || a_bc !== v.bc) begin
      n_fail++;
      $display("FAIL row%0d: got ov=%b od=%h occ=%0d ir=%b sc=%0d bc=%0d expected ov=%b od=%h occ=%0d ir=%b sc=%0d bc=%0d",
               i, a_out_valid, a_out_data[15:0], a_occ, a_in_ready, a_sc, a_bc,
               v.ov, v.od, v.occ, v.ir, v.sc, v.bc);
    end
  endtask

  initial begin
    //        iv  d        ordy st  fl   ov  od       occ ir  sc  bc
    tbl[0]  = '{1, 16'h0001, 1, 0, 0,   1, 16'h0001, 1, 1,  0,  1};
    tbl[1]  = '{1, 16'h0002, 1, 0, 0,   1, 16'h0002, 1, 1,  0,  1};
    tbl[2]  = '{1, 16'h0003, 1, 0, 0,   1, 16'h0003, 1, 1,  0,  1};
    tbl[3]  = '{0, 16'h0000, 1, 0, 0,   0, 16'h0003, 0, 1,  0,  1};
    tbl[4]  = '{1, 16'h000A, 0, 0, 0,   1, 16'h000A, 1, 1,  0,  1};
    tbl[5]  = '{1, 16'h000B, 0, 0, 0,   1, 16'h000A, 2, 0,  1,  1};
    tbl[6]  = '{1, 16'h000C, 0, 0, 0,   1, 16'h000A, 2, 0,  2,  1};
    tbl[7]  = '{1, 16'h000C, 1, 0, 0,   1, 16'h000B, 1, 1,  2,  1};
    tbl[8]  = '{1, 16'h000C, 1, 0, 0,   1, 16'h000C, 1, 1,  2,  1};
    tbl[9]  = '{0, 16'h0000, 0, 0, 0,   1, 16'h000C, 1, 1,  3,  1};
    tbl[10] = '{1, 16'h000D, 0, 0, 0,   1, 16'h000C, 2, 0,  4,  1};
    tbl[11] = '{1, 16'h000E, 1, 1, 0,   1, 16'h000C, 2, 0,  5,  1};
    tbl[12] = '{1, 16'h000E, 1, 1, 1,   0, 16'h0000, 0, 1,  5,  1};
    tbl[13] = '{1, 16'h0011, 0, 0, 0,   1, 16'h0011, 1, 1,  5,  1};
    tbl[14] = '{1, 16'h0022, 1, 1, 0,   1, 16'h0011, 1, 1,  6,  1};
    tbl[15] = '{1, 16'h0022, 1, 1, 0,   1, 16'h0011, 1, 1,  7,  1};
    tbl[16] = '{1, 16'h0022, 1, 1, 0,   1, 16'h0011, 1, 1,  8,  1};
    tbl[17] = '{1, 16'h0022, 1, 1, 0,   1, 16'h0011, 1, 1,  9,  1};
    tbl[18] = '{1, 16'h0022, 1, 1, 0,   1, 16'h0011, 1, 1, 10,  1};
    tbl[19] = '{0, 16'h0000, 1, 0, 0,   0, 16'h0011, 0, 1, 10,  1};
    tbl[20] = '{0, 16'h0000, 1, 0, 0,   0, 16'h0011, 0, 1, 10,  2};

    // Reset state while Rst is held
    @(posedge Clk);
    #1;
    chk("rst_out_valid", AW'(a_out_valid), '0);
    chk("rst_out_data",  a_out_data, '0);
    chk("rst_occ",       AW'(a_occ), '0);
    chk("rst_in_ready",  AW'(a_in_ready), '0);
    chk("rst_cnts",      AW'({a_sc, a_bc}), '0);
    Rst = 1'b0;
    #1;
    chk("post_rst_in_ready", AW'(a_in_ready), AW'(1));

    for (int i = 0; i < int'(NV); i++) begin
      a_in_valid  = tbl[i].iv;
      a_in_data   = AW'(tbl[i].d);
      a_out_ready = tbl[i].ordy;
      a_stall     = tbl[i].st;
      a_flush     = tbl[i].fl;
      a_cycle();
      check_a_row(i, tbl[i]);
    end

    // Mid-operation reset: entry and counters vanish without a clock edge
    a_in_valid  = 1'b1;
    a_in_data   = AW'(16'h0033);
    a_out_ready = 1'b0;
    a_cycle();
    chk("pre_rst_data", a_out_data, AW'(16'h0033));
    a_in_valid = 1'b0;
    Rst = 1'b1;
    #1;
    chk("async_rst_valid", AW'(a_out_valid), '0);
    chk("async_rst_data",  a_out_data, '0);
    chk("async_rst_cnts",  AW'({a_sc, a_bc}), '0);
    Rst = 1'b0;
    #1;
    chk("async_rst_in_ready", AW'(a_in_ready), AW'(1));

    // Instance B: updates only on rising edges, bubble counter saturates at 7
    @(posedge Clk);
    #1;
    b_out_ready = 1'b1;
    chk("b_bc_start", AW'(b_bc), '0);
    @(negedge Clk);
    #1;
    chk("b_bc_no_negedge", AW'(b_bc), '0);
    @(posedge Clk);
    #1;
    chk("b_bc_posedge", AW'(b_bc), AW'(1));
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
    end
    chk("b_bc_seven", AW'(b_bc), AW'(7));
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
    end
    chk("b_bc_saturated", AW'(b_bc), AW'(7));
    chk("b_sc_zero", AW'(b_sc), '0);

    // Instance B pass-through visible only after a rising edge
    b_in_valid = 1'b1;
    b_in_data  = 8'h5A;
    @(negedge Clk);
    #1;
    chk("b_valid_no_negedge", AW'(b_out_valid), '0);
    b_in_valid = 1'b1;
    @(posedge Clk);
    #1;
    b_in_valid = 1'b0;
    chk("b_valid_posedge", AW'(b_out_valid), AW'(1));
    chk("b_data_posedge", AW'(b_out_data), AW'(8'h5A));
    chk("b_occ", AW'(b_occ), AW'(1));
    chk("b_in_ready", AW'(b_in_ready), AW'(1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
